// File: rtl/lif_tdm_scheduler.sv
// Time-multiplexed leaky integrate-and-fire tile: NUM_NEURONS virtual neurons
// share one update datapath, scanned one neuron per cycle after each accepted
// tick, with the timestep's spikes published together at the end.
module lif_tdm_scheduler #(
  parameter int NUM_NEURONS = 4,
  parameter int VW          = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   tick,
  input  logic [NUM_NEURONS-1:0] spike_in,
  input  logic                   cfg_we,
  input  logic [1:0]             cfg_addr,
  input  logic [VW-1:0]          cfg_data,
  output logic [NUM_NEURONS-1:0] spike_out,
  output logic                   spike_valid,
  output logic                   busy,
  output logic                   tick_drop
);

  localparam int IW = $clog2(NUM_NEURONS);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_PUBLISH} state_e;

  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;

  // Live configuration registers (writable at any time)
  logic [VW-1:0] thr_q, wgt_q;
  logic [2:0]    leak_q;
  logic [3:0]    refr_q;

  // Shadow copies frozen for the duration of one scan
  logic [VW-1:0]          thr_sh_q, wgt_sh_q;
  logic [2:0]             leak_sh_q;
  logic [3:0]             refr_sh_q;
  logic [NUM_NEURONS-1:0] sin_sh_q;

  // Persistent per-neuron state
  logic [VW-1:0] v_q [NUM_NEURONS];
  logic [3:0]    r_q [NUM_NEURONS];

  logic [NUM_NEURONS-1:0] acc_q, acc_d;
  logic [NUM_NEURONS-1:0] spike_out_q;
  logic                   tick_drop_q;

  logic accept, scanning, last_idx;
  logic [NUM_NEURONS-1:0] upd_en;

  assign accept   = (state_q == S_IDLE) && ena && tick;
  assign scanning = (state_q == S_SCAN);
  assign last_idx = (idx_q == IW'(NUM_NEURONS - 1));

  // Shared neuron update datapath, operating on the neuron selected by idx_q
  logic [VW-1:0] v_cur, leak_amt, u_sat, v_new;
  logic [3:0]    r_cur, r_new;
  logic [VW:0]   u_raw;
  logic          fire;

  // Leak, integrate, saturate and threshold the currently scanned neuron
  always_comb begin
    v_cur    = v_q[idx_q];
    r_cur    = r_q[idx_q];
    leak_amt = (leak_sh_q != 3'd0) ? (v_cur >> leak_sh_q) : '0;
    // leak never exceeds V, so the subtraction cannot wrap below zero
    u_raw    = {1'b0, v_cur} - {1'b0, leak_amt}
             + (sin_sh_q[idx_q] ? {1'b0, wgt_sh_q} : {(VW+1){1'b0}});
    u_sat    = u_raw[VW] ? {VW{1'b1}} : u_raw[VW-1:0];
    fire     = 1'b0;
    v_new    = u_sat;
    r_new    = 4'd0;
    if (r_cur != 4'd0) begin
      v_new = '0;
      r_new = r_cur - 4'd1;
    end else if (u_sat >= thr_sh_q) begin
      fire  = 1'b1;
      v_new = '0;
      r_new = refr_sh_q;
    end
  end

  // Per-neuron write enables: only the scanned neuron is updated
  generate
    for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_upd
      assign upd_en[gi] = scanning && (idx_q == IW'(gi));
    end
  endgenerate

  // Spike bits collected so far in this scan, including the current neuron
  always_comb begin
    acc_d = acc_q;
    if (scanning) acc_d[idx_q] = fire;
  end

  // FSM state and scan index register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (accept) state_d = S_SCAN;
      end
      S_SCAN: begin
        if (last_idx) begin
          state_d = S_PUBLISH;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_PUBLISH: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy        = (state_q != S_IDLE);
    spike_valid = (state_q == S_PUBLISH);
  end

  assign spike_out = spike_out_q;
  assign tick_drop = tick_drop_q;

  // Live configuration writes, honoured in every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_q  <= VW'(200);
      leak_q <= 3'd2;
      wgt_q  <= VW'(64);
      refr_q <= 4'd2;
    end else if (cfg_we) begin
      case (cfg_addr)
        2'd0: thr_q  <= cfg_data;
        2'd1: leak_q <= cfg_data[2:0];
        2'd2: wgt_q  <= cfg_data;
        2'd3: refr_q <= cfg_data[3:0];
        default: ;
      endcase
    end
  end

  // Freeze inputs and configuration when a tick is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_sh_q  <= '0;
      leak_sh_q <= '0;
      wgt_sh_q  <= '0;
      refr_sh_q <= '0;
      sin_sh_q  <= '0;
    end else if (accept) begin
      thr_sh_q  <= thr_q;
      leak_sh_q <= leak_q;
      wgt_sh_q  <= wgt_q;
      refr_sh_q <= refr_q;
      sin_sh_q  <= spike_in;
    end
  end

  // Membrane and refractory state write-back for the scanned neuron
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        v_q[i] <= '0;
        r_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (upd_en[i]) begin
          v_q[i] <= v_new;
          r_q[i] <= r_new;
        end
      end
    end
  end

  // Spike accumulation, publish register and dropped-tick pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      spike_out_q <= '0;
      tick_drop_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      tick_drop_q <= tick && ena && (state_q != S_IDLE);
      if (scanning && last_idx) spike_out_q <= acc_d;
    end
  end

endmodule
